// File: rtl/alu_step_sequencer.sv
// Control-step sequencer for op Rd,Ra,Rb: fetch T0-T2, execute T3-T5.
// Define ALU_SEQ_MULDIV_EN to add mul/div (T5 lo, T6 hi) and lo_in/hi_in/zhigh_out.
module alu_step_sequencer #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                run,
    input  logic                mem_rdy,
    input  logic [DATA_W-1:0]   ir,
    output logic                pc_out,
    output logic                inc_pc,
    output logic                z_in,
    output logic                mar_in,
    output logic                pc_in,
    output logic                zlow_out,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [OPC_W-1:0]    alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
`ifdef ALU_SEQ_MULDIV_EN
    ,
    output logic                lo_in,
    output logic                hi_in,
    output logic                zhigh_out
`endif
);
    localparam int REG_W = $clog2(NUM_REGS);
    localparam int RD_HI = DATA_W - OPC_W - 1;
    localparam int RA_HI = RD_HI - REG_W;
    localparam int RB_HI = RA_HI - REG_W;

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic inc_pc;
        logic z_in;
        logic mar_in;
        logic pc_in;
        logic zlow_out;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
`ifdef ALU_SEQ_MULDIV_EN
        logic lo_in;
        logic hi_in;
        logic zhigh_out;
`endif
        logic busy;
        logic done;
        logic illegal;
    } strb_t;

    state_t              state_q, state_d;
    strb_t               strb_q, strb_d;
    logic [NUM_REGS-1:0] ro_q, ro_d;
    logic [NUM_REGS-1:0] ri_q, ri_d;
    logic [OPC_W-1:0]    alu_q, alu_d;

    logic [OPC_W-1:0] opc;
    logic [REG_W-1:0] rd, ra, rb;
    logic             is_alu, is_md, regs_ok, legal, last;
    logic             unused_ir;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_W-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign opc = ir[DATA_W-1 -: OPC_W];
    assign rd  = ir[RD_HI -: REG_W];
    assign ra  = ir[RA_HI -: REG_W];
    assign rb  = ir[RB_HI -: REG_W];
    assign unused_ir = ^ir;

    assign is_alu = (opc >= OPC_W'(3)) && (opc <= OPC_W'(11));
`ifdef ALU_SEQ_MULDIV_EN
    assign is_md = (opc == OPC_W'(15)) || (opc == OPC_W'(16));
`else
    assign is_md = 1'b0;
`endif
    assign regs_ok = (int'(rd) < NUM_REGS) && (int'(ra) < NUM_REGS)
                  && (int'(rb) < NUM_REGS);
    assign legal = (is_alu || is_md) && regs_ok;
    assign last  = ((state_q == T5) && !is_md) || (state_q == T6);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = T0;
            T0:      state_d = T1;
            T1:      if (mem_rdy) state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = legal ? T4 : IDLE;
            T4:      state_d = T5;
            T5:      state_d = is_md ? T6 : (run ? T0 : IDLE);
`ifdef ALU_SEQ_MULDIV_EN
            T6:      state_d = run ? T0 : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they are registered.
    always_comb begin
        strb_d         = '0;
        ro_d           = '0;
        ri_d           = '0;
        alu_d          = '0;
        strb_d.busy    = (state_d != IDLE);
        strb_d.done    = last;
        strb_d.illegal = (state_q == T3) && !legal;
        unique case (state_d)
            T0: begin
                strb_d.pc_out = 1'b1;
                strb_d.mar_in = 1'b1;
                strb_d.inc_pc = 1'b1;
                strb_d.z_in   = 1'b1;
            end
            T1: begin
                strb_d.zlow_out = 1'b1;
                strb_d.pc_in    = 1'b1;
                strb_d.read     = 1'b1;
                strb_d.mdr_in   = 1'b1;
            end
            T2: begin
                strb_d.mdr_out = 1'b1;
                strb_d.ir_in   = 1'b1;
            end
            T4: begin
                ro_d        = onehot(rb);
                strb_d.z_in = 1'b1;
                alu_d       = opc;
            end
            T5: begin
                strb_d.zlow_out = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (is_md) strb_d.lo_in = 1'b1;
                else       ri_d = onehot(rd);
`else
                ri_d = onehot(rd);
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            T6: begin
                strb_d.zhigh_out = 1'b1;
                strb_d.hi_in     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            strb_q  <= '0;
            ro_q    <= '0;
            ri_q    <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            ro_q    <= ro_d;
            ri_q    <= ri_d;
            alu_q   <= alu_d;
        end
    end

    // IR is only loaded at the end of T2, so the T3 Ra drive decodes it live.
    assign y_in    = (state_q == T3) && legal;
    assign reg_out = ro_q | (y_in ? onehot(ra) : '0);
    assign reg_in  = ri_q;
    assign alu_op  = alu_q;

    assign pc_out   = strb_q.pc_out;
    assign inc_pc   = strb_q.inc_pc;
    assign z_in     = strb_q.z_in;
    assign mar_in   = strb_q.mar_in;
    assign pc_in    = strb_q.pc_in;
    assign zlow_out = strb_q.zlow_out;
    assign read     = strb_q.read;
    assign mdr_in   = strb_q.mdr_in;
    assign mdr_out  = strb_q.mdr_out;
    assign ir_in    = strb_q.ir_in;
    assign busy     = strb_q.busy;
    assign done     = strb_q.done;
    assign illegal  = strb_q.illegal;
`ifdef ALU_SEQ_MULDIV_EN
    assign lo_in     = strb_q.lo_in;
    assign hi_in     = strb_q.hi_in;
    assign zhigh_out = strb_q.zhigh_out;
`endif

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Scoreboard bench for alu_step_sequencer: stimulus queues expected
// register-strobe / done / illegal events, a negedge monitor checks them.
module tb_alu_step_sequencer;
  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        run = 1'b0;
  logic        mem_rdy = 1'b1;
  logic [31:0] ir = '0;

  logic        pc_out, inc_pc, z_in, mar_in, pc_in;
  logic        zlow_out, read, mdr_in, mdr_out, ir_in, y_in;
  logic [15:0] reg_out, reg_in;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;
  logic        lo_w, hi_w, zh_w;

  always #5 clk = ~clk;

  alu_step_sequencer #(
    .DATA_W(32), .NUM_REGS(16), .OPC_W(5)
  ) dut (
    .clock(clk), .clear(clear), .start(start),
    .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .pc_out(pc_out), .inc_pc(inc_pc), .z_in(z_in),
    .mar_in(mar_in), .pc_in(pc_in),
    .zlow_out(zlow_out), .read(read),
    .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in),
    .reg_out(reg_out), .reg_in(reg_in),
    .alu_op(alu_op), .busy(busy),
    .done(done), .illegal(illegal)
`ifdef ALU_SEQ_MULDIV_EN
    ,
    .lo_in(lo_w), .hi_in(hi_w),
    .zhigh_out(zh_w)
`endif
  );

`ifndef ALU_SEQ_MULDIV_EN
  assign lo_w = 1'b0;
  assign hi_w = 1'b0;
  assign zh_w = 1'b0;
`endif

  wire [52:0] all_o = {pc_out, inc_pc, z_in, mar_in,
    pc_in, zlow_out, read, mdr_in, mdr_out, ir_in,
    y_in, reg_out, reg_in, alu_op, busy, done,
    illegal, lo_w, hi_w};

  typedef struct {
    int          cyc;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  alu;
    logic        dn, il, bz, lo, hi;
  } ev_t;

  ev_t q[$];
  ev_t e;
  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  read_cnt = 0;
  int  n_ev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (read && mdr_in) read_cnt <= read_cnt + 1;

  always @(negedge clk) begin
    if (clear && (reg_out != 0 || reg_in != 0
        || alu_op != 0 || done || illegal
        || lo_w || hi_w)) begin
      n_tests++;
      n_ev++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ev%0d cyc=%0d ro=%h ri=%h alu=%h dn=%b il=%b required no event",
          n_ev, cyc, reg_out, reg_in, alu_op, done, illegal);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ro != reg_out
            || e.ri != reg_in || e.alu != alu_op
            || e.dn != done || e.il != illegal
            || e.bz != busy || e.lo != lo_w
            || e.hi != hi_w || e.hi != zh_w) begin
          n_fail++;
          $display("FAIL ev%0d got cyc=%0d ro=%h ri=%h alu=%h dn,il,bz,lo,hi,zh=%b%b%b%b%b%b required cyc=%0d ro=%h ri=%h alu=%h dn,il,bz,lo,hi,zh=%b%b%b%b%b%b",
            n_ev, cyc, reg_out, reg_in, alu_op,
            done, illegal, busy, lo_w, hi_w, zh_w,
            e.cyc, e.ro, e.ri, e.alu,
            e.dn, e.il, e.bz, e.lo, e.hi, e.hi);
        end
      end
    end
  end

  function automatic logic [31:0] mk_ir(
    input logic [4:0] op, input logic [3:0] rd,
    input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb, 15'b0};
  endfunction

  task automatic push_ev(input int c,
    input logic [15:0] ro, input logic [15:0] ri,
    input logic [4:0] alu, input logic dn,
    input logic il, input logic bz,
    input logic lo, input logic hi);
    ev_t ne;
    ne.cyc = c;  ne.ro = ro;  ne.ri = ri;
    ne.alu = alu; ne.dn = dn; ne.il = il;
    ne.bz = bz;  ne.lo = lo;  ne.hi = hi;
    q.push_back(ne);
  endtask

  task automatic exp_legal(input int s, input int w,
    input logic [31:0] ins, input logic rn);
    logic [15:0] one;
    one = 16'h0001;
    push_ev(s + 3 + w, one << ins[22:19], 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 4 + w, one << ins[18:15], 16'h0, ins[31:27], 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 5 + w, 16'h0, one << ins[26:23], 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 6 + w, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, rn, 1'b0, 1'b0);
  endtask

  task automatic exp_illegal(input int s);
    push_ev(s + 4, 16'h0, 16'h0, 5'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [31:0] ins, output int s);
    @(negedge clk);
    ir = ins;
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s_timeout busy=%b required 0", tag, busy);
    end
  endtask

  int          s;
  int          base;
  logic [31:0] ins;
  logic [31:0] ins2;

  initial begin
    repeat (2) @(negedge clk);
    n_tests++;
    if (all_o != '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h required 0", all_o);
    end
    clear = 1'b1;

    // and R1,R6,R7 with hand-computed strobes
    base = read_cnt;
    issue(32'h28B38000, s);
    push_ev(s + 3, 16'h0040, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 4, 16'h0080, 16'h0, 5'b00101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 5, 16'h0, 16'h0002, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 6, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("and");
    n_tests++;
    if (read_cnt - base != 1) begin
      n_fail++;
      $display("FAIL read_nowait got=%0d required 1", read_cnt - base);
    end

    // three T1 wait cycles
    base = read_cnt;
    mem_rdy = 1'b0;
    issue(32'h28B38000, s);
    exp_legal(s, 3, 32'h28B38000, 1'b0);
    repeat (4) @(negedge clk);
    mem_rdy = 1'b1;
    wait_idle("wait");
    n_tests++;
    if (read_cnt - base != 4) begin
      n_fail++;
      $display("FAIL read_held got=%0d required 4", read_cnt - base);
    end

    // opcode range boundaries: add (3) and rol (11)
    ins = mk_ir(5'd3, 4'd2, 4'd0, 4'd15);
    issue(ins, s);
    push_ev(s + 3, 16'h0001, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 4, 16'h8000, 16'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 5, 16'h0, 16'h0004, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 6, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("add");
    ins = mk_ir(5'd11, 4'd15, 4'd9, 4'd9);
    issue(ins, s);
    push_ev(s + 3, 16'h0200, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 4, 16'h0200, 16'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 5, 16'h0, 16'h8000, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 6, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("rol");

    // illegal opcodes
    issue(mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), s);
    exp_illegal(s);
    wait_idle("ill31");
    issue(mk_ir(5'd2, 4'd1, 4'd2, 4'd3), s);
    exp_illegal(s);
    wait_idle("ill2");
    issue(mk_ir(5'd12, 4'd1, 4'd2, 4'd3), s);
    exp_illegal(s);
    wait_idle("ill12");
`ifndef ALU_SEQ_MULDIV_EN
    issue(mk_ir(5'd15, 4'd1, 4'd3, 4'd4), s);
    exp_illegal(s);
    wait_idle("mul_off");
`endif

    // back-to-back with run
    ins  = mk_ir(5'd3, 4'd4, 4'd5, 4'd6);
    ins2 = mk_ir(5'd4, 4'd2, 4'd3, 4'd4);
    run = 1'b1;
    issue(ins, s);
    exp_legal(s, 0, ins, 1'b1);
    exp_legal(s + 6, 0, ins2, 1'b0);
    repeat (6) @(negedge clk);
    run = 1'b0;
    ir = ins2;
    wait_idle("run");

    // clear during T4
    ins = mk_ir(5'd6, 4'd3, 4'd8, 4'd10);
    issue(ins, s);
    push_ev(s + 3, 16'h0100, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 4, 16'h0400, 16'h0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 clear = 1'b0;
    #1;
    n_tests++;
    if (all_o != '0) begin
      n_fail++;
      $display("FAIL clear_abort got=%h required 0", all_o);
    end
    @(negedge clk);
    clear = 1'b1;
    ins = mk_ir(5'd7, 4'd0, 4'd1, 4'd2);
    issue(ins, s);
    n_tests++;
    if ({pc_out, mar_in, inc_pc, z_in, busy, read} != 6'b111110) begin
      n_fail++;
      $display("FAIL t0_after_clear got=%b required 111110",
        {pc_out, mar_in, inc_pc, z_in, busy, read});
    end
    exp_legal(s, 0, ins, 1'b0);
    wait_idle("after_clear");

`ifdef ALU_SEQ_MULDIV_EN
    ins = mk_ir(5'd15, 4'd9, 4'd3, 4'd4);
    issue(ins, s);
    push_ev(s + 3, 16'h0008, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 4, 16'h0010, 16'h0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_ev(s + 5, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_ev(s + 6, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ev(s + 7, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("mul");
`endif

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got=%0d pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
